// File: rtl/apb4_gpio_ctrl_pkg.sv
// Shared constants for the APB4 GPIO controller: register offsets and
// filter geometry.
package apb4_gpio_ctrl_pkg;
  localparam int GPIO_MAX   = 32;
  localparam int HIST_DEPTH = 3;

  localparam logic [5:0] OFF_DIR    = 6'h00;
  localparam logic [5:0] OFF_IN     = 6'h04;
  localparam logic [5:0] OFF_OUT    = 6'h08;
  localparam logic [5:0] OFF_OUTSET = 6'h0C;
  localparam logic [5:0] OFF_OUTCLR = 6'h10;
  localparam logic [5:0] OFF_OUTTGL = 6'h14;
  localparam logic [5:0] OFF_INTEN  = 6'h18;
  localparam logic [5:0] OFF_MODE   = 6'h1C;
  localparam logic [5:0] OFF_POL    = 6'h20;
  localparam logic [5:0] OFF_BOTH   = 6'h24;
  localparam logic [5:0] OFF_PEND   = 6'h28;
  localparam logic [5:0] OFF_DBEN   = 6'h2C;
  localparam logic [5:0] OFF_DBDIV  = 6'h30;
  localparam logic [5:0] OFF_IOF    = 6'h34;
endpackage

// File: rtl/gpio_in_filt.sv
// Input conditioning: pad synchroniser, shared debounce prescaler, per-pin
// 3-sample agreement filter, and the delayed copy used for edge detection.
module gpio_in_filt
  import apb4_gpio_ctrl_pkg::*;
#(
  parameter int GPIO_NUM    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_DIV_W    = 16
) (
  input  logic                hclk,
  input  logic                hrst,
  input  logic [GPIO_NUM-1:0] pin,
  input  logic [GPIO_NUM-1:0] dben,
  input  logic [DB_DIV_W-1:0] dbdiv,
  input  logic                div_wr,
  output logic [GPIO_NUM-1:0] f,
  output logic [GPIO_NUM-1:0] fd
);
  logic [SYNC_STAGES-1:0][GPIO_NUM-1:0] sync;
  logic [GPIO_NUM-1:0]                  s, filt, dben_q;
  logic [GPIO_NUM-1:0][HIST_DEPTH-1:0]  hist;
  logic [DB_DIV_W-1:0]                  cnt;
  logic                                 tick;

  assign s    = sync[SYNC_STAGES-1];
  assign tick = (cnt == dbdiv);

  always_ff @(posedge hclk or posedge hrst)
    if (hrst) sync <= '0;
    else      sync <= {sync[SYNC_STAGES-2:0], pin};

  always_ff @(posedge hclk or posedge hrst)
    if (hrst)              cnt <= '0;
    else if (div_wr | tick) cnt <= '0;
    else                   cnt <= cnt + DB_DIV_W'(1);

  always_ff @(posedge hclk or posedge hrst)
    if (hrst) dben_q <= '0;
    else      dben_q <= dben;

  // While unfiltered, filt tracks s so enabling the filter starts from the
  // current level instead of a stale one.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      hist <= '0;
      filt <= '0;
    end else begin
      for (int i = 0; i < GPIO_NUM; i++) begin
        if (dben[i] != dben_q[i]) begin
          hist[i] <= {HIST_DEPTH{s[i]}};
        end else if (dben[i] && tick) begin
          hist[i] <= {hist[i][HIST_DEPTH-2:0], s[i]};
          if ((&{hist[i][HIST_DEPTH-2:0], s[i]}) || !(|{hist[i][HIST_DEPTH-2:0], s[i]}))
            filt[i] <= s[i];
        end
        if (!dben[i]) filt[i] <= s[i];
      end
    end
  end

  assign f = (dben & filt) | (~dben & s);

  always_ff @(posedge hclk or posedge hrst)
    if (hrst) fd <= '0;
    else      fd <= f;
endmodule

// File: rtl/apb4_gpio_ctrl.sv
// APB4 GPIO bank: register file, bus decode, atomic output updates and
// sticky per-pin interrupt pending with edge/level detection.
module apb4_gpio_ctrl
  import apb4_gpio_ctrl_pkg::*;
#(
  parameter int GPIO_NUM    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_DIV_W    = 16
) (
  input  logic                hclk,
  input  logic                hrst,
  input  logic [5:0]          paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [31:0]         pwdata,
  input  logic [3:0]          pstrb,
  output logic [31:0]         prdata,
  output logic                pready,
  output logic                pslverr,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_dir_o,
  output logic [GPIO_NUM-1:0] gpio_iof_o,
  output logic                irq_o
);
  logic [GPIO_NUM-1:0] dir, out, inten, mode, pol, both, pend, dben, iof;
  logic [GPIO_NUM-1:0] wd, f, fd, edge_set, set, clr;
  logic [DB_DIV_W-1:0] dbdiv;
  logic [5:0]          off;
  logic                access, err, wr_en, rd_en, div_wr;
  logic                unused_bits;

  assign off         = {paddr[5:2], 2'b00};
  assign access      = psel & penable;
  assign wd          = pwdata[GPIO_NUM-1:0];
  assign unused_bits = ^{pstrb, paddr[1:0], pwdata};

  always_comb begin
    err = 1'b0;
    case (off)
      OFF_IN:                             err = pwrite;
      OFF_OUTSET, OFF_OUTCLR, OFF_OUTTGL: err = ~pwrite;
      OFF_DIR, OFF_OUT, OFF_INTEN, OFF_MODE, OFF_POL, OFF_BOTH,
      OFF_PEND, OFF_DBEN, OFF_DBDIV, OFF_IOF: err = 1'b0;
      default:                            err = 1'b1;
    endcase
  end

  assign wr_en   = access & pwrite & ~err;
  assign rd_en   = access & ~pwrite & ~err;
  assign div_wr  = wr_en & (off == OFF_DBDIV);
  assign pslverr = access & err;
  assign pready  = 1'b1;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      dir   <= '0;
      out   <= '0;
      inten <= '0;
      mode  <= '0;
      pol   <= '0;
      both  <= '0;
      dben  <= '0;
      dbdiv <= '0;
      iof   <= '0;
    end else if (wr_en) begin
      case (off)
        OFF_DIR:    dir   <= wd;
        OFF_OUT:    out   <= wd;
        OFF_OUTSET: out   <= out | wd;
        OFF_OUTCLR: out   <= out & ~wd;
        OFF_OUTTGL: out   <= out ^ wd;
        OFF_INTEN:  inten <= wd;
        OFF_MODE:   mode  <= wd;
        OFF_POL:    pol   <= wd;
        OFF_BOTH:   both  <= wd;
        OFF_DBEN:   dben  <= wd;
        OFF_DBDIV:  dbdiv <= pwdata[DB_DIV_W-1:0];
        OFF_IOF:    iof   <= wd;
        default: ;
      endcase
    end
  end

  gpio_in_filt #(
    .GPIO_NUM    (GPIO_NUM),
    .SYNC_STAGES (SYNC_STAGES),
    .DB_DIV_W    (DB_DIV_W)
  ) u_filt (
    .hclk   (hclk),
    .hrst   (hrst),
    .pin    (gpio_in_i),
    .dben   (dben),
    .dbdiv  (dbdiv),
    .div_wr (div_wr),
    .f      (f),
    .fd     (fd)
  );

  // Level mode pends while f matches ~pol; edge mode compares f against fd.
  assign edge_set = (both & (f ^ fd))
                  | (~both & ~pol & f & ~fd)
                  | (~both & pol & ~f & fd);
  assign set      = (~mode & edge_set) | (mode & (f ^ pol));
  assign clr      = (wr_en && off == OFF_PEND) ? wd : '0;

  always_ff @(posedge hclk or posedge hrst)
    if (hrst) pend <= '0;
    else      pend <= (pend & ~clr) | set;

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (off)
        OFF_DIR:   prdata = 32'(dir);
        OFF_IN:    prdata = 32'(f);
        OFF_OUT:   prdata = 32'(out);
        OFF_INTEN: prdata = 32'(inten);
        OFF_MODE:  prdata = 32'(mode);
        OFF_POL:   prdata = 32'(pol);
        OFF_BOTH:  prdata = 32'(both);
        OFF_PEND:  prdata = 32'(pend);
        OFF_DBEN:  prdata = 32'(dben);
        OFF_DBDIV: prdata = 32'(dbdiv);
        OFF_IOF:   prdata = 32'(iof);
        default:   prdata = '0;
      endcase
    end
  end

  assign gpio_out_o = out;
  assign gpio_dir_o = dir;
  assign gpio_iof_o = iof;
  assign irq_o      = |(pend & inten);
endmodule

// File: doc/apb4_gpio_ctrl.md
# apb4_gpio_ctrl

Parametrised second-generation APB4 GPIO controller, one instance per pad bank on the peripheral bus. Adds to the existing GPIO feature set: pin count from 1 to 32, configurable synchroniser depth, atomic set/clear/toggle of outputs, and a prescaled input debounce filter. Interrupts use per-pin sticky pending bits, cleared by write-1-to-clear (W1C), with edge (rise/fall/both) and level (high/low) modes. Drives the pad mux (`dir`/`out`/`iof`) and one `irq_o` line to the interrupt controller.

## Interface
- `GPIO_NUM`, 32 — number of pins, 1..32.
- `SYNC_STAGES`, 2 — input synchroniser flops, ≥2.
- `DB_DIV_W`, 16 — width of the debounce prescaler divisor.
- `hclk` in 1 — single clock.
- `hrst` in 1 — asynchronous, active-high reset.
- `paddr` in 6 — byte address; `paddr[5:2]` selects the register.
- `psel`, `penable`, `pwrite` in 1 — APB4 control.
- `pwdata` in 32 — write data.
- `pstrb` in 4 — ignored; all writes are full-word.
- `prdata` out 32 — read data.
- `pready` out 1 — tied 1.
- `pslverr` out 1 — access error.
- `gpio_in_i` in GPIO_NUM — raw pad inputs.
- `gpio_out_o`, `gpio_dir_o`, `gpio_iof_o` out GPIO_NUM — pad output value, direction (1 = output), alternate-function select.
- `irq_o` out 1 — `|(PEND & INTEN)`.

## Operation
- Register map (offset, access):
  - `DIR` 0x00 RW; `IN` 0x04 RO (filtered input); `OUT` 0x08 RW.
  - `OUTSET` 0x0C WO, `OUTCLR` 0x10 WO, `OUTTGL` 0x14 WO — write-1 bits set, clear or toggle `OUT`.
  - `INTEN` 0x18, `MODE` 0x1C (0 = edge, 1 = level), `POL` 0x20, `BOTH` 0x24 — all RW.
  - `PEND` 0x28 RW1C; `DBEN` 0x2C RW; `DBDIV` 0x30 RW (DB_DIV_W bits); `IOF` 0x34 RW.
- All registers are GPIO_NUM wide. Unused `prdata` bits read 0; unused `pwdata` bits are dropped.
- A write commits on `psel & penable & pwrite`. `prdata` is driven only during an access phase, else 0.
- `pslverr=1` on:
  - an unmapped offset (0x38, 0x3C);
  - a write to `IN`;
  - a read of `OUTSET`, `OUTCLR` or `OUTTGL`.
- An erroring access changes no state and returns `prdata=0`.
- Input path per pin: `SYNC_STAGES` flops give `s`, then the filter gives `f`, which is what `IN` shows.
  - `DBEN[i]=0`: `f=s`.
  - `DBEN[i]=1`: a shared prescaler counts 0..`DBDIV` and emits `tick` on the wrap; `DBDIV=0` means `tick` every cycle.
  - On `tick`, each filtered pin shifts `s` into a 3-deep history. `f` takes the new value only when all 3 samples agree.
  - A write to `DBDIV` restarts the prescaler at 0.
  - Toggling `DBEN[i]` reloads that pin's history with `s`.
- A register `fd` holds the previous `f`; edge detection compares `f` against `fd`.
- Pending-set conditions for pin i:
  - `MODE=0`, `BOTH=1`: `f≠fd`.
  - `MODE=0`, `BOTH=0`, `POL=0`: rising edge (`f & ~fd`).
  - `MODE=0`, `BOTH=0`, `POL=1`: falling edge (`~f & fd`).
  - `MODE=1`, `POL=0`: `f=1`. `MODE=1`, `POL=1`: `f=0`.
- `PEND[i]` is set regardless of `INTEN`; `INTEN` only masks `irq_o`.
- W1C to `PEND` clears the written bits. A set condition in the same cycle wins and the bit stays 1.
- Level mode re-pends the cycle after a clear while the level persists.
- `OUT` write priority: at most one APB write per cycle, so no conflicts arise.

## Timing
- Reset values: every register 0. Outputs `gpio_out_o`, `gpio_dir_o`, `gpio_iof_o`, `irq_o`, `prdata` and `pslverr` are 0; `pready` is 1. Sync, history and prescaler flops are 0.
- Unfiltered path: a pin change sampled at edge N reaches `IN` at edge N+SYNC_STAGES−1. `PEND` sets at edge N+SYNC_STAGES.
- `irq_o` is combinational from the `PEND` and `INTEN` flops, so there is no extra cycle.
- Filtered path: `f` follows a stable input within 3·(`DBDIV`+1)+SYNC_STAGES cycles. A pulse shorter than 2·(`DBDIV`+1) cycles never reaches `f`.
- A write takes effect on the edge closing the access phase; outputs update on that edge.
- Reads are zero-wait.
- Asserting `hrst` mid-operation clears all state immediately, including pending bits, with no spurious `irq_o` on release.

## Structure
- Package `apb4_gpio_ctrl_pkg`:
  - register offset constants;
  - `GPIO_MAX=32`;
  - `localparam` for history depth 3.
- Sub-module `gpio_in_filt`: synchroniser, prescaler, debounce history and `fd`. Outputs `f` and `fd`, GPIO_NUM wide.
- The top level holds the register file, APB decode and interrupt logic.

## Test plan
- Reset / RO / error checks:
  - After reset, all reads return 0 and `irq_o=0`.
  - Reading 0x38 gives `pslverr=1`, `prdata=0`.
  - Writing `IN` gives `pslverr=1` and `IN` is unchanged.
- Atomic outputs:
  - `OUT=0x0000_00F0`, then `OUTSET=0x3`, `OUTCLR=0x10`, `OUTTGL=0x101` → `gpio_out_o=0x0000_01E2`.
- Rising edge, no debounce:
  - `INTEN[5]=1`, `MODE=0`, `POL=0`; pin 5 goes 0→1 at edge N.
  - `PEND=0x20` and `irq_o=1` at N+2.
  - W1C `PEND=0x20` drops `irq_o`; pin 5 going 1→0 does not re-pend.
- Both edges and level-low:
  - `BOTH[0]=1` with a pulse on pin 0 → `PEND[0]` set twice (cleared in between).
  - Pin 1 at `MODE=1`, `POL=1` held low → W1C is immediately re-pended; driving the pin high and clearing leaves it 0.
- Debounce:
  - `DBEN[2]=1`, `DBDIV=9`.
  - A 15-cycle glitch → `IN[2]` unchanged, no pend.
  - A stable step → `IN[2]` changes within 32 cycles.
- Simultaneous W1C and set on the same bit → bit remains 1.
- `hrst` pulsed while `irq_o=1` → `irq_o` and all registers read 0 afterwards.
